// File: rtl/aes_mode_pkg.sv
// Shared definitions for the AES block-mode controller: FSM encodings, mode
// constants, block width and the CBC unchaining XOR.
package aes_mode_pkg;

    localparam int BLOCK_W = 128;

    typedef enum logic [1:0] {
        CTRL_IDLE   = 2'd0,
        CTRL_START  = 2'd1,
        CTRL_WAIT   = 2'd2,
        CTRL_OUTPUT = 2'd3
    } ctrl_state_t;

    localparam logic MODE_ECB = 1'b0;
    localparam logic MODE_CBC = 1'b1;

    // ECB passes the core result straight through; CBC folds in the previous ciphertext/IV.
    function automatic logic [BLOCK_W-1:0] cbc_unchain(
        input logic [BLOCK_W-1:0] core_res,
        input logic [BLOCK_W-1:0] chain,
        input logic               mode
    );
        return core_res ^ ((mode == MODE_CBC) ? chain : {BLOCK_W{1'b0}});
    endfunction

endpackage

// File: rtl/aes_cbc_dec_ctrl.sv
// Purpose: launches one AES decipher per ciphertext block and applies CBC/ECB unchaining.
// Latency: accept edge + 1 START cycle + core latency + 1 edge to out_valid.
// Backpressure: single block in flight; in_ready low outside IDLE, out_block held until out_ready.
module aes_cbc_dec_ctrl
    import aes_mode_pkg::*;
#(
    parameter int CTR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 key_ready,
    input  logic                 cbc_en,
    input  logic                 iv_load,
    input  logic [127:0]         iv,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         in_block,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         out_block,
    output logic                 core_next,
    output logic [127:0]         core_block,
    input  logic                 core_ready,
    input  logic [127:0]         core_result,
    output logic                 busy,
    output logic [CTR_WIDTH-1:0] blocks_done
);

    ctrl_state_t        state;
    logic [BLOCK_W-1:0] chain_reg;
    logic [BLOCK_W-1:0] cblk_reg;
    logic               mode_reg;

    // An IV load in the same cycle takes priority over accepting a block.
    assign in_ready   = reset_n && (state == CTRL_IDLE) && key_ready && !iv_load;
    assign busy       = (state != CTRL_IDLE);
    assign core_block = cblk_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= CTRL_IDLE;
            chain_reg   <= '0;
            cblk_reg    <= '0;
            mode_reg    <= MODE_ECB;
            out_block   <= '0;
            out_valid   <= 1'b0;
            core_next   <= 1'b0;
            blocks_done <= '0;
        end else begin
            case (state)
                CTRL_IDLE: begin
                    if (iv_load) begin
                        chain_reg <= iv;
                    end
                    if (in_valid && in_ready) begin
                        cblk_reg  <= in_block;
                        mode_reg  <= cbc_en;
                        core_next <= 1'b1;
                        state     <= CTRL_START;
                    end
                end
                CTRL_START: begin
                    core_next <= 1'b0;
                    state     <= CTRL_WAIT;
                end
                CTRL_WAIT: begin
                    if (core_ready) begin
                        out_block <= cbc_unchain(core_result, chain_reg, mode_reg);
                        // ECB blocks leave the chain alone so a later CBC block continues it.
                        if (mode_reg == MODE_CBC) begin
                            chain_reg <= cblk_reg;
                        end
                        out_valid <= 1'b1;
                        state     <= CTRL_OUTPUT;
                    end
                end
                CTRL_OUTPUT: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        blocks_done <= blocks_done + CTR_WIDTH'(1);
                        state       <= CTRL_IDLE;
                    end
                end
                default: state <= CTRL_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cbc_dec_ctrl.sv
// Bench for aes_cbc_dec_ctrl: behavioural AES-128 decipher core plus a transaction-level
// CBC/ECB model checked every cycle, and NIST SP800-38A vectors as literal anchors.
module tb_aes_cbc_dec_ctrl;

    localparam int TB_CTR_W = 2;
    localparam int CORE_LAT = 10;

    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] C3  = 128'h73bed6b8e3c1743b7116e69e22229516;
    localparam logic [127:0] C4  = 128'h3ff1caa1681fac09120eca307586e1a7;
    localparam logic [127:0] E1  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] E2  = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] E3  = 128'h43b1cd7f598ece23881b00e3ed030688;
    localparam logic [127:0] E4  = 128'h7b0c785e27e8ad3f8223207104725dd4;
    localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] P3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] P4  = 128'hf69f2445df4f9b17ad2b417be66c3710;
    // D(C1) with an all-zero chain, i.e. P1 ^ IV0.
    localparam logic [127:0] P1_NOIV = 128'h6bc0bce12a459991e134741a7f9e1925;

    logic                clk = 1'b0;
    logic                reset_n, key_ready, cbc_en, iv_load, in_valid, out_ready;
    logic [127:0]        iv, in_block;
    logic                in_ready, out_valid, core_next, busy;
    logic [127:0]        out_block, core_block;
    logic [TB_CTR_W-1:0] blocks_done;
    logic                core_ready  = 1'b1;
    logic [127:0]        core_result = '0;
    logic [127:0]        core_ct     = '0;
    int                  core_cnt    = 0;

    int n_vec  = 0;
    int n_err  = 0;
    int n_next = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    aes_cbc_dec_ctrl #(.CTR_WIDTH(TB_CTR_W)) dut (
        .clk(clk), .reset_n(reset_n), .key_ready(key_ready), .cbc_en(cbc_en),
        .iv_load(iv_load), .iv(iv), .in_valid(in_valid), .in_ready(in_ready),
        .in_block(in_block), .out_valid(out_valid), .out_ready(out_ready),
        .out_block(out_block), .core_next(core_next), .core_block(core_block),
        .core_ready(core_ready), .core_result(core_result), .busy(busy),
        .blocks_done(blocks_done)
    );

    // ---------------- AES-128 inverse cipher (key memory = rk) ----------------
    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk    [11];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] inv_mix(input logic [127:0] v);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = v[127 - 32*c -: 8]; a1 = v[119 - 32*c -: 8];
            a2 = v[111 - 32*c -: 8]; a3 = v[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] ct);
        logic [7:0]   st  [16];
        logic [7:0]   tmp [16];
        logic [127:0] v;
        v = ct ^ rk[10];
        for (int r = 9; r >= 0; r--) begin
            for (int i = 0; i < 16; i++) st[i] = v[127 - 8*i -: 8];
            // byte (row, col) lives at index 4*col + row
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++)
                    tmp[4*c + rw] = isbox[st[4*((c - rw + 4) % 4) + rw]];
            for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = tmp[i];
            v = v ^ rk[r];
            if (r > 0) v = inv_mix(v);
        end
        return v;
    endfunction

    // Decipher core: drops core_ready on the edge that samples core_next.
    always @(posedge clk) begin
        if (core_next) begin
            core_ready  <= 1'b0;
            core_cnt    <= CORE_LAT;
            core_ct     <= core_block;
            core_result <= '1;
        end else if (!core_ready) begin
            if (core_cnt <= 1) begin
                core_ready  <= 1'b1;
                core_result <= aes_dec(core_ct);
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    bit           m_inflight = 1'b0;
    bit           m_launch   = 1'b0;
    bit           m_have     = 1'b0;
    logic [127:0] m_chain    = '0;
    logic [127:0] m_cblk     = '0;
    logic [127:0] m_pend     = '0;
    logic [127:0] m_out      = '0;
    int           m_count    = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_inflight <= 1'b0; m_launch <= 1'b0; m_have <= 1'b0;
            m_chain <= '0; m_cblk <= '0; m_out <= '0; m_count <= 0;
        end else if (m_have) begin
            if (out_ready) begin
                m_have     <= 1'b0;
                m_inflight <= 1'b0;
                m_count    <= (m_count + 1) % (1 << TB_CTR_W);
            end
        end else if (m_inflight) begin
            if (m_launch) m_launch <= 1'b0;
            else if (core_ready) begin
                m_have <= 1'b1;
                m_out  <= m_pend;
            end
        end else if (iv_load) begin
            m_chain <= iv;
        end else if (in_valid && key_ready) begin
            m_cblk     <= in_block;
            m_pend     <= aes_dec(in_block) ^ (cbc_en ? m_chain : 128'h0);
            if (cbc_en) m_chain <= in_block;
            m_inflight <= 1'b1;
            m_launch   <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: no response within cycle budget, expected one", name);
    endtask

    initial forever begin
        @(negedge clk);
        if (core_next === 1'b1) n_next++;
        if (chk_en) begin
            check("cyc_in_ready", 128'(in_ready), 128'(reset_n && !m_inflight && key_ready && !iv_load));
            check("cyc_busy", 128'(busy), 128'(m_inflight));
            check("cyc_core_next", 128'(core_next), 128'(m_launch));
            check("cyc_out_valid", 128'(out_valid), 128'(m_have));
            check("cyc_out_block", out_block, m_out);
            check("cyc_core_block", core_block, m_cblk);
            check("cyc_blocks_done", 128'(blocks_done), 128'(m_count));
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [127:0] ct, input logic cbc);
        bit ok = 1'b0;
        in_block = ct; cbc_en = cbc; in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ok) timeout("accept");
    endtask

    task automatic wait_out(output logic [127:0] got);
        bit ok = 1'b0;
        got = '0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok  = 1'b1;
                got = out_block;
            end
        end
        if (!ok) timeout("out_valid");
    endtask

    task automatic run_block(input string name, input logic [127:0] ct, input logic cbc,
                             input logic [127:0] exp);
        logic [127:0] got;
        send(ct, cbc);
        wait_out(got);
        step();
        check(name, got, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] got;
        int           nn;
        bit           ok;
        reset_n = 1'b0; key_ready = 1'b1; cbc_en = 1'b0; iv_load = 1'b0; iv = '0;
        in_valid = 1'b1; in_block = C1; out_ready = 1'b1;
        build_tables();
        expand_key(KEY);
        step();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_blocks_done", 128'(blocks_done), 128'(0));
        check("rst_out_block", out_block, 128'h0);
        @(posedge clk); #1;
        in_valid = 1'b0; reset_n = 1'b1;

        // CBC chain from the IV
        iv = IV0; iv_load = 1'b1; step(); iv_load = 1'b0;
        run_block("cbc_blk1", C1, 1'b1, P1);
        run_block("cbc_blk2", C2, 1'b1, P2);
        check("cbc_count", 128'(blocks_done), 128'(2));

        // ECB block, then CBC continues from C2
        run_block("ecb_blk", E1, 1'b0, P1);
        run_block("cbc_after_ecb", C3, 1'b1, P3);
        check("count_wrap4", 128'(blocks_done), 128'(0));

        // output backpressure
        out_ready = 1'b0;
        send(C4, 1'b1);
        wait_out(got);
        check("bp_first", got, P4);
        nn = n_next;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_block = C1; cbc_en = 1'b1;
            @(negedge clk);
            check("bp_valid", 128'(out_valid), 128'(1));
            check("bp_data", out_block, P4);
            check("bp_in_ready", 128'(in_ready), 128'(0));
        end
        check("bp_no_repulse", 128'(n_next), 128'(nn));
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("bp_busy_after", 128'(busy), 128'(0));
        check("bp_valid_after", 128'(out_valid), 128'(0));
        check("bp_count", 128'(blocks_done), 128'(1));

        // iv_load and in_valid together in IDLE
        iv = IV0; iv_load = 1'b1; in_valid = 1'b1; in_block = C1; cbc_en = 1'b1;
        @(negedge clk);
        check("ivl_in_ready_low", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        iv_load = 1'b0;
        @(negedge clk);
        check("ivl_accept_next", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(got);
        step();
        check("ivl_result", got, P1);

        // iv_load during WAIT is ignored
        send(C2, 1'b1);
        step();
        iv = '1; iv_load = 1'b1; step(); iv_load = 1'b0;
        wait_out(got);
        step();
        check("ivl_wait_ignored", got, P2);
        check("ivl_count", 128'(blocks_done), 128'(3));

        // key_ready gating
        key_ready = 1'b0; in_valid = 1'b1; in_block = C3; cbc_en = 1'b1;
        nn = n_next;
        repeat (5) begin
            @(negedge clk);
            check("nokey_in_ready", 128'(in_ready), 128'(0));
        end
        @(posedge clk); #1;
        check("nokey_no_next", 128'(n_next), 128'(nn));
        key_ready = 1'b1;
        send(C3, 1'b1);
        wait_out(got);
        step();
        check("key_result", got, P3);
        check("key_one_pulse", 128'(n_next), 128'(nn + 1));

        // reset during WAIT clears chain and counter
        send(C4, 1'b1);
        step();
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("wrst_busy", 128'(busy), 128'(0));
        check("wrst_out_valid", 128'(out_valid), 128'(0));
        check("wrst_blocks_done", 128'(blocks_done), 128'(0));
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (core_ready) ok = 1'b1;
        end
        if (!ok) timeout("core_idle");
        step();
        run_block("wrst_chain_zero", C1, 1'b1, P1_NOIV);

        // counter wrap with a 2-bit counter: five blocks since reset
        run_block("ecb_v1", E1, 1'b0, P1);
        run_block("ecb_v2", E2, 1'b0, P2);
        run_block("ecb_v3", E3, 1'b0, P3);
        run_block("ecb_v4", E4, 1'b0, P4);
        check("count_five_wrap", 128'(blocks_done), 128'(1));

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
